// File: rtl/impulse_pkg.sv
// Shared types for the noise oscillator sequencer: command opcodes, FSM states
// and the default period width.
package impulse_pkg;

  localparam int NOISE_PERIOD_W = 17;

  typedef enum logic [1:0] {
    NOTE_ON   = 2'd0,
    SET_LEN   = 2'd1,
    NOTE_OFF  = 2'd2,
    SET_SWEEP = 2'd3
  } noise_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2
  } noise_ctrl_state_e;

endpackage

// File: rtl/noise_sweep.sv
// Period sweep for noise_ctrl: divides sample ticks down to sweep steps and
// computes the next period, saturated to [MIN_PERIOD, 2^PERIOD_W-1].
module noise_sweep
  import impulse_pkg::*;
#(
  parameter int PERIOD_W   = NOISE_PERIOD_W,
  parameter int MIN_PERIOD = 1,
  parameter int SWEEP_DIV  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                tick,
  input  logic                load,
  input  logic [PERIOD_W-1:0] cfg,
  input  logic [PERIOD_W-1:0] period,
  output logic                apply,
  output logic [PERIOD_W-1:0] period_next
);

  localparam int STEP_W = PERIOD_W - 1;
  localparam int EXT_W  = PERIOD_W + 1;
  localparam int CNT_W  = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

  localparam logic [EXT_W-1:0] MAX_EXT = {1'b0, {PERIOD_W{1'b1}}};
  localparam logic [EXT_W-1:0] MIN_EXT = EXT_W'(MIN_PERIOD);

  logic              dir_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wrap;
  logic [EXT_W-1:0]  sum;
  logic [EXT_W-1:0]  diff;

  assign wrap  = (cnt_q == CNT_W'(SWEEP_DIV - 1));
  assign apply = tick && wrap && (step_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= 1'b0;
      step_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load) begin
        dir_q  <= cfg[PERIOD_W-1];
        step_q <= cfg[STEP_W-1:0];
      end
      if (clear) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  assign sum  = {1'b0, period} + EXT_W'(step_q);
  assign diff = {1'b0, period} - EXT_W'(step_q);

  // NOTE: default assigned first so no path through always_comb leaves period_next unassigned (no latch).
  always_comb begin
    period_next = period;
    if (dir_q) begin
      if (sum > MAX_EXT)      period_next = MAX_EXT[PERIOD_W-1:0];
      else if (sum < MIN_EXT) period_next = MIN_EXT[PERIOD_W-1:0];
      else                    period_next = sum[PERIOD_W-1:0];
    end else begin
      // A set top bit means the subtraction borrowed below zero.
      if (diff[PERIOD_W] || (diff < MIN_EXT)) period_next = MIN_EXT[PERIOD_W-1:0];
      else                                    period_next = diff[PERIOD_W-1:0];
    end
  end

endmodule

// File: rtl/noise_ctrl.sv
// Noise oscillator sequencer: command decode, IDLE/START/PLAY FSM and note-length
// counter. Define NOISE_CTRL_SWEEP_EN to build the period sweep (noise_sweep).
module noise_ctrl
  import impulse_pkg::*;
#(
  parameter int PERIOD_W   = NOISE_PERIOD_W,
  parameter int LEN_W      = 16,
  parameter int MIN_PERIOD = 1,
  parameter int SWEEP_DIV  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [PERIOD_W-1:0] cmd_data,
  output logic                osc_en,
  output logic                osc_rst,
  output logic [PERIOD_W-1:0] osc_period,
  output logic                busy,
  output logic                done
);

  noise_ctrl_state_e state_q, state_d;
  noise_cmd_e        op;
  logic [PERIOD_W-1:0] period_q;
  logic [LEN_W-1:0]    len_reg_q;
  logic [LEN_W-1:0]    len_cnt_q;
  logic                accept;
  logic                tick_play;
  logic                expire;
  logic                note_on;
  logic                sweep_apply;
  logic [PERIOD_W-1:0] sweep_period;

  assign op        = noise_cmd_e'(cmd_op);
  assign cmd_ready = !rst && (state_q != START);
  assign accept    = cmd_valid && cmd_ready;
  assign note_on   = accept && (op == NOTE_ON);
  // An accepted command pre-empts any tick-driven length or sweep update this cycle.
  assign tick_play = sample_tick && (state_q == PLAY) && !accept;
  assign expire    = tick_play && (len_cnt_q == LEN_W'(1));

  assign osc_en     = (state_q == PLAY);
  assign osc_rst    = rst || (state_q == START);
  assign osc_period = period_q;
  assign busy       = (state_q != IDLE);
  assign done       = !rst && expire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (note_on) state_d = START;
      START: state_d = PLAY;
      PLAY: begin
        if (accept && (op == NOTE_ON))       state_d = START;
        else if (accept && (op == NOTE_OFF)) state_d = IDLE;
        else if (expire)                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      len_reg_q <= '0;
      len_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (op == NOTE_ON) begin
          period_q  <= cmd_data;
          len_cnt_q <= len_reg_q;
        end
        if (op == SET_LEN) len_reg_q <= cmd_data[LEN_W-1:0];
      end else begin
        if (tick_play && (len_cnt_q != '0)) len_cnt_q <= len_cnt_q - LEN_W'(1);
        if (sweep_apply) period_q <= sweep_period;
      end
    end
  end

`ifdef NOISE_CTRL_SWEEP_EN
  noise_sweep #(
    .PERIOD_W  (PERIOD_W),
    .MIN_PERIOD(MIN_PERIOD),
    .SWEEP_DIV (SWEEP_DIV)
  ) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .clear      (note_on),
    .tick       (tick_play),
    .load       (accept && (op == SET_SWEEP)),
    .cfg        (cmd_data),
    .period     (period_q),
    .apply      (sweep_apply),
    .period_next(sweep_period)
  );
`else
  // Without the sweep, SET_SWEEP is accepted and dropped.
  assign sweep_apply  = 1'b0;
  assign sweep_period = '0;
`endif

endmodule

// File: tb/tb_noise_ctrl.sv
// Self-checking bench for noise_ctrl: directed note scenarios with literal
// expectations, then random traffic compared every cycle against a note model.
module tb_noise_ctrl;
  import impulse_pkg::*;

  localparam int PW   = 17;
  localparam int DIV  = 2;
  localparam int MINP = 1;
  localparam int MAXP = (1 << PW) - 1;
`ifdef NOISE_CTRL_SWEEP_EN
  localparam bit SWEEP_ON = 1'b1;
`else
  localparam bit SWEEP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [PW-1:0] cmd_data = '0;
  logic          osc_en, osc_rst, busy, done;
  logic [PW-1:0] osc_period;

  int n_compared = 0;
  int n_failed   = 0;

  noise_ctrl #(.PERIOD_W(PW), .LEN_W(16), .MIN_PERIOD(MINP), .SWEEP_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .osc_en     (osc_en),
    .osc_rst    (osc_rst),
    .osc_period (osc_period),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold for the whole cycle.
  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [PW-1:0] d, input logic t);
    @(posedge clk);
    #1;
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d; sample_tick = t;
    #1;
  endtask

  task automatic idle(input logic t);
    drive(1'b0, 1'b0, 2'd0, '0, t);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [PW-1:0] d, input logic t);
    drive(1'b0, 1'b1, op, d, t);
  endtask

  // Reference model: the note is silent, starting (one cycle) or playing.
  localparam int PH_IDLE = 0, PH_START = 1, PH_PLAY = 2;
  int  m_phase = PH_IDLE;
  int  m_period = 0, m_len = 0, m_rem = 0, m_ticks = 0, m_step = 0;
  bit  m_up = 1'b0;
  bit  model_on = 1'b0;

  function automatic int clamp(input int v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return v;
  endfunction

  initial begin
    @(posedge clk);
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      bit ready, acc, tick, exp_done;
      ready    = !rst && (m_phase != PH_START);
      acc      = cmd_valid && ready;
      tick     = sample_tick && (m_phase == PH_PLAY) && !acc;
      exp_done = !rst && tick && (m_rem == 1);

      check("m_cmd_ready",  {31'd0, cmd_ready}, {31'd0, ready});
      check("m_osc_en",     {31'd0, osc_en},    {31'd0, m_phase == PH_PLAY});
      check("m_osc_rst",    {31'd0, osc_rst},   {31'd0, rst || (m_phase == PH_START)});
      check("m_busy",       {31'd0, busy},      {31'd0, m_phase != PH_IDLE});
      check("m_done",       {31'd0, done},      {31'd0, exp_done});
      check("m_osc_period", {15'd0, osc_period}, m_period);

      if (rst) begin
        m_phase = PH_IDLE; m_period = 0; m_len = 0; m_rem = 0;
        m_ticks = 0; m_step = 0; m_up = 1'b0;
      end else if (acc) begin
        case (cmd_op)
          2'd0: begin m_period = cmd_data; m_rem = m_len; m_ticks = 0; m_phase = PH_START; end
          2'd1: m_len = cmd_data[15:0];
          2'd2: m_phase = PH_IDLE;
          default: if (SWEEP_ON) begin m_up = cmd_data[16]; m_step = cmd_data[15:0]; end
        endcase
      end else if (m_phase == PH_START) begin
        m_phase = PH_PLAY;
      end else if (tick) begin
        if (m_rem != 0) begin
          m_rem--;
          if (m_rem == 0) m_phase = PH_IDLE;
        end
        if (SWEEP_ON) begin
          m_ticks++;
          if (m_ticks == DIV) begin
            m_ticks = 0;
            if (m_step != 0) m_period = clamp(m_up ? m_period + m_step : m_period - m_step);
          end
        end
      end
    end
  end

  initial begin
    // 1: reset, then an infinite note at period 100.
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, '0, 1'b1);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_osc_rst",   {31'd0, osc_rst},   32'd1);
    check("rst_done",      {31'd0, done},      32'd0);
    idle(1'b0);
    check("reset_osc_en", {31'd0, osc_en}, 32'd0);
    check("reset_period", {15'd0, osc_period}, 32'd0);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_ready",  {31'd0, cmd_ready}, 32'd1);
    cmd(NOTE_ON, 17'd100, 1'b0);
    idle(1'b1);
    check("start_osc_rst", {31'd0, osc_rst}, 32'd1);
    check("start_osc_en",  {31'd0, osc_en},  32'd0);
    check("start_ready",   {31'd0, cmd_ready}, 32'd0);
    check("start_period",  {15'd0, osc_period}, 32'd100);
    idle(1'b1);
    check("play_osc_en",  {31'd0, osc_en}, 32'd1);
    check("play_period",  {15'd0, osc_period}, 32'd100);
    check("play_osc_rst", {31'd0, osc_rst}, 32'd0);
    repeat (4) idle(1'b1);
    check("len0_busy", {31'd0, busy}, 32'd1);
    check("len0_done", {31'd0, done}, 32'd0);

    // 2: length 3 expires on the third tick.
    cmd(SET_LEN, 17'd3, 1'b0);
    cmd(NOTE_ON, 17'd50, 1'b0);
    idle(1'b1);
    idle(1'b1); check("len3_tick1_done", {31'd0, done}, 32'd0);
    idle(1'b1); check("len3_tick2_done", {31'd0, done}, 32'd0);
    idle(1'b1); check("len3_tick3_done", {31'd0, done}, 32'd1);
    idle(1'b0);
    check("len3_after_en",   {31'd0, osc_en}, 32'd0);
    check("len3_after_busy", {31'd0, busy},   32'd0);
    check("len3_after_done", {31'd0, done},   32'd0);

    // 3: retrigger on the expiry tick suppresses done and reloads the length.
    cmd(SET_LEN, 17'd2, 1'b0);
    cmd(NOTE_ON, 17'd50, 1'b0);
    idle(1'b0);
    idle(1'b1);
    cmd(NOTE_ON, 17'd80, 1'b1);
    check("retrig_done",  {31'd0, done}, 32'd0);
    check("retrig_ready", {31'd0, cmd_ready}, 32'd1);
    idle(1'b0);
    check("retrig_start",  {31'd0, osc_rst}, 32'd1);
    check("retrig_period", {15'd0, osc_period}, 32'd80);
    idle(1'b1); check("retrig_tick1_done", {31'd0, done}, 32'd0);
    idle(1'b1); check("retrig_tick2_done", {31'd0, done}, 32'd1);

    // 4: NOTE_OFF mid-note and in IDLE.
    cmd(SET_LEN, 17'd0, 1'b0);
    cmd(NOTE_ON, 17'd7, 1'b0);
    idle(1'b0);
    cmd(NOTE_OFF, 17'd0, 1'b1);
    check("off_done", {31'd0, done}, 32'd0);
    check("off_busy_before", {31'd0, busy}, 32'd1);
    idle(1'b0);
    check("off_busy",   {31'd0, busy},   32'd0);
    check("off_osc_en", {31'd0, osc_en}, 32'd0);
    cmd(NOTE_OFF, 17'd0, 1'b0);
    check("off_idle_ready", {31'd0, cmd_ready}, 32'd1);
    idle(1'b0);
    check("off_idle_busy",   {31'd0, busy}, 32'd0);
    check("off_idle_period", {15'd0, osc_period}, 32'd7);

    // 5: sweep saturation at both bounds.
    cmd(SET_SWEEP, 17'h1FFFF, 1'b0);
    cmd(NOTE_ON, 17'h1FFF0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("sweep_up_sat", {15'd0, osc_period}, SWEEP_ON ? 32'h1FFFF : 32'h1FFF0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("sweep_up_hold", {15'd0, osc_period}, SWEEP_ON ? 32'h1FFFF : 32'h1FFF0);
    check("sweep_up_busy", {31'd0, busy}, 32'd1);
    cmd(SET_SWEEP, 17'h0000A, 1'b0);
    cmd(NOTE_ON, 17'd5, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("sweep_down_sat", {15'd0, osc_period}, SWEEP_ON ? 32'd1 : 32'd5);

    // 6: reset while playing.
    drive(1'b1, 1'b0, 2'd0, '0, 1'b1);
    check("midrst_ready",   {31'd0, cmd_ready}, 32'd0);
    check("midrst_osc_rst", {31'd0, osc_rst}, 32'd1);
    check("midrst_done",    {31'd0, done}, 32'd0);
    idle(1'b0);
    check("midrst_osc_en", {31'd0, osc_en}, 32'd0);
    check("midrst_period", {15'd0, osc_period}, 32'd0);
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done2",  {31'd0, done}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic          r, v, t;
      logic [1:0]    op;
      logic [PW-1:0] d;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 9) < 3);
      t  = ($urandom_range(0, 9) < 4);
      op = 2'($urandom_range(0, 3));
      d  = PW'($urandom);
      case (op)
        2'd0: case ($urandom_range(0, 3))
                0: d = PW'($urandom_range(0, 20));
                1: d = PW'(MAXP - $urandom_range(0, 20));
                default: d = PW'($urandom);
              endcase
        2'd1: d = PW'($urandom_range(0, 6));
        2'd3: if ($urandom_range(0, 1) == 1) d = {d[16], 16'($urandom_range(0, 3))};
        default: ;
      endcase
      drive(r, v, op, d, t);
    end
    idle(1'b0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
